// File: rtl/axi_stream_protocol_checker.sv
// Passive AXI4-Stream protocol checker: sticky violation flags plus saturating
// beat/packet/byte counters for a single observed stream.
module axi_stream_protocol_checker #(
  parameter int BYTE_WIDTH       = 4,
  parameter int ID_WIDTH         = 1,
  parameter int DEST_WIDTH       = 1,
  parameter int USER_WIDTH       = 1,
  parameter int CNT_WIDTH        = 32,
  parameter int MAX_STALL        = 256,
  parameter int MAX_PKT_BEATS    = 1024,
  parameter int ALLOW_INTERLEAVE = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tvalid,
  input  logic                    tready,
  input  logic [8*BYTE_WIDTH-1:0] tdata,
  input  logic [BYTE_WIDTH-1:0]   tstrb,
  input  logic [BYTE_WIDTH-1:0]   tkeep,
  input  logic                    tlast,
  input  logic [ID_WIDTH-1:0]     tid,
  input  logic [DEST_WIDTH-1:0]   tdest,
  input  logic [USER_WIDTH-1:0]   tuser,
  input  logic                    err_clear,
  input  logic                    stat_clear,
  output logic [6:0]              err_flags,
  output logic                    err_any,
  output logic [2:0]              err_first,
  output logic                    in_packet,
  output logic [CNT_WIDTH-1:0]    beat_cnt,
  output logic [CNT_WIDTH-1:0]    pkt_cnt,
  output logic [CNT_WIDTH-1:0]    byte_cnt,
  output logic [CNT_WIDTH-1:0]    pkt_beats
);

  localparam int PW  = 8*BYTE_WIDTH + 2*BYTE_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam int SW  = $clog2(MAX_STALL + 2);
  localparam int BCW = $clog2(BYTE_WIDTH + 1);

  typedef enum logic {IDLE, PKT} state_t;

  state_t                  state_q;
  logic                    held_q;
  logic [PW-1:0]           cap_q;
  logic [SW-1:0]           stall_q;
  logic                    last_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [DEST_WIDTH-1:0]   dest_q;

  logic                    hs, stall, any_eff;
  logic [PW-1:0]           payload;
  logic [SW-1:0]           stall_nxt;
  logic [CNT_WIDTH-1:0]    pkt_base;
  logic [BCW-1:0]          keep_cnt;
  logic [6:0]              new_err;
  logic [2:0]              first_idx;

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [CNT_WIDTH-1:0] b);
    logic [CNT_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  assign hs      = tvalid && tready;
  assign stall   = tvalid && !tready;
  assign payload = {tdata, tstrb, tkeep, tlast, tid, tdest, tuser};
  assign any_eff = err_any && !err_clear;
  // pkt_beats still shows the finished packet for one cycle after its tlast beat
  assign pkt_base = last_q ? '0 : pkt_beats;

  always_comb begin
    stall_nxt = '0;
    if (stall)
      stall_nxt = (stall_q == SW'(MAX_STALL)) ? stall_q : stall_q + 1'b1;
  end

  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < BYTE_WIDTH; i++)
      keep_cnt = keep_cnt + BCW'(tkeep[i]);
  end

  always_comb begin
    new_err    = '0;
    new_err[0] = held_q && !tvalid;
    new_err[1] = held_q && tvalid && (payload != cap_q);
    new_err[2] = tvalid && |(tstrb & ~tkeep);
    new_err[3] = reset && tvalid;
    new_err[4] = (MAX_STALL != 0) && stall && (stall_nxt == SW'(MAX_STALL));
    new_err[5] = (MAX_PKT_BEATS != 0) && hs && (pkt_base == CNT_WIDTH'(MAX_PKT_BEATS));
    new_err[6] = (ALLOW_INTERLEAVE == 0) && (state_q == PKT) && hs &&
                 ((tid != id_q) || (tdest != dest_q));
  end

  always_comb begin
    first_idx = '0;
    for (int i = 6; i >= 0; i--)
      if (new_err[i]) first_idx = 3'(i);
  end

  assign err_any   = |err_flags;
  assign in_packet = (state_q == PKT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      held_q    <= 1'b0;
      cap_q     <= '0;
      stall_q   <= '0;
      last_q    <= 1'b0;
      id_q      <= '0;
      dest_q    <= '0;
      beat_cnt  <= '0;
      pkt_cnt   <= '0;
      byte_cnt  <= '0;
      pkt_beats <= '0;
      // a source driving tvalid during reset is still worth reporting
      err_flags <= {3'b000, new_err[3], 3'b000};
      err_first <= new_err[3] ? 3'd3 : 3'd0;
    end else begin
      held_q  <= stall;
      if (stall) cap_q <= payload;
      stall_q <= stall_nxt;
      last_q  <= hs && tlast;

      if (hs) begin
        if (state_q == IDLE) begin
          id_q   <= tid;
          dest_q <= tdest;
        end
        state_q   <= tlast ? IDLE : PKT;
        pkt_beats <= sat_add(pkt_base, CNT_WIDTH'(1));
      end else if (last_q) begin
        pkt_beats <= '0;
      end

      err_flags <= (err_clear ? 7'd0 : err_flags) | new_err;
      if (!any_eff && |new_err) err_first <= first_idx;
      else if (err_clear)       err_first <= '0;

      beat_cnt <= sat_add(stat_clear ? '0 : beat_cnt, CNT_WIDTH'(hs));
      pkt_cnt  <= sat_add(stat_clear ? '0 : pkt_cnt,  CNT_WIDTH'(hs && tlast));
      byte_cnt <= sat_add(stat_clear ? '0 : byte_cnt, hs ? CNT_WIDTH'(keep_cnt) : '0);
    end
  end

endmodule

// File: tb/tb_axi_stream_protocol_checker.sv
// Directed scenarios with literal expectations, then randomized traffic checked
// every cycle against an unbounded-integer model of the checker rules.
module tb_axi_stream_protocol_checker;
  localparam int BW = 4, IDW = 2, DSW = 2, UW = 1, CW = 8;
  localparam int MS = 4, MPB = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset, tvalid, tready, tlast, err_clear, stat_clear;
  logic [8*BW-1:0] tdata;
  logic [BW-1:0] tstrb, tkeep;
  logic [IDW-1:0] tid;
  logic [DSW-1:0] tdest;
  logic [UW-1:0] tuser;
  logic [6:0] err_flags;
  logic err_any, in_packet;
  logic [2:0] err_first;
  logic [CW-1:0] beat_cnt, pkt_cnt, byte_cnt, pkt_beats;

  int checks = 0, failures = 0;

  axi_stream_protocol_checker #(
    .BYTE_WIDTH(BW), .ID_WIDTH(IDW), .DEST_WIDTH(DSW), .USER_WIDTH(UW),
    .CNT_WIDTH(CW), .MAX_STALL(MS), .MAX_PKT_BEATS(MPB), .ALLOW_INTERLEAVE(0)
  ) dut (
    .clk(clk), .reset(reset), .tvalid(tvalid), .tready(tready), .tdata(tdata),
    .tstrb(tstrb), .tkeep(tkeep), .tlast(tlast), .tid(tid), .tdest(tdest),
    .tuser(tuser), .err_clear(err_clear), .stat_clear(stat_clear),
    .err_flags(err_flags), .err_any(err_any), .err_first(err_first),
    .in_packet(in_packet), .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt),
    .byte_cnt(byte_cnt), .pkt_beats(pkt_beats)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model state
  bit [6:0] m_flags;
  int m_first, m_beat, m_pkt, m_byte, m_len, m_run;
  bit m_ended, m_inpkt, m_held;
  logic [8*BW-1:0] c_data;
  logic [BW-1:0] c_strb, c_keep;
  logic c_last;
  logic [IDW-1:0] c_id, l_id;
  logic [DSW-1:0] c_dest, l_dest;
  logic [UW-1:0] c_user;

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  always @(posedge clk) begin
    bit hs, st;
    bit [6:0] ne;
    hs = tvalid && tready;
    st = tvalid && !tready;
    if (reset) begin
      m_flags = tvalid ? 7'h08 : 7'h00;
      m_first = tvalid ? 3 : 0;
      m_beat = 0; m_pkt = 0; m_byte = 0; m_len = 0; m_run = 0;
      m_ended = 0; m_inpkt = 0; m_held = 0;
    end else begin
      ne = '0;
      ne[0] = m_held && !tvalid;
      ne[1] = m_held && tvalid && (tdata != c_data || tstrb != c_strb || tkeep != c_keep ||
              tlast != c_last || tid != c_id || tdest != c_dest || tuser != c_user);
      ne[2] = tvalid && ((tstrb & ~tkeep) != 0);
      m_run = st ? m_run + 1 : 0;
      ne[4] = st && (m_run >= MS);
      if (m_ended) m_len = 0;
      if (hs) begin
        m_len++;
        ne[5] = (m_len == MPB + 1);
        ne[6] = m_inpkt && (tid != l_id || tdest != l_dest);
        if (!m_inpkt) begin l_id = tid; l_dest = tdest; end
        m_inpkt = !tlast;
      end
      m_ended = hs && tlast;
      m_held = st;
      if (st) begin
        c_data = tdata; c_strb = tstrb; c_keep = tkeep; c_last = tlast;
        c_id = tid; c_dest = tdest; c_user = tuser;
      end
      if (stat_clear) begin m_beat = 0; m_pkt = 0; m_byte = 0; end
      if (hs) begin
        m_beat++;
        m_pkt += int'(tlast);
        m_byte += $countones(tkeep);
      end
      if (err_clear) begin m_flags = '0; m_first = 0; end
      if (m_flags == 0 && ne != 0)
        for (int i = 6; i >= 0; i--) if (ne[i]) m_first = i;
      m_flags |= ne;
    end
    #1;
    chk("err_flags", 64'(err_flags), 64'(m_flags));
    chk("err_any", 64'(err_any), 64'(m_flags != 0));
    if (m_flags != 0) chk("err_first", 64'(err_first), 64'(m_first));
    chk("in_packet", 64'(in_packet), 64'(m_inpkt));
    chk("beat_cnt", 64'(beat_cnt), 64'(sat(m_beat)));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(sat(m_pkt)));
    chk("byte_cnt", 64'(byte_cnt), 64'(sat(m_byte)));
    chk("pkt_beats", 64'(pkt_beats), 64'(sat(m_len)));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    tvalid = 0; tready = 0; tdata = '0; tstrb = 4'hF; tkeep = 4'hF; tlast = 0;
    tid = '0; tdest = '0; tuser = '0; err_clear = 0; stat_clear = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  initial begin
    reset = 1;
    idle();
    tick(); tick();
    chk("reset_flags", 64'(err_flags), 64'h0);
    chk("reset_beats", 64'(beat_cnt), 64'h0);
    reset = 0;

    // 1: stalled stable beat then accepted
    tvalid = 1; tdata = 32'hA5A5A5A5;
    repeat (3) tick();
    tready = 1;
    tick();
    chk("t1_flags", 64'(err_flags), 64'h0);
    chk("t1_beat", 64'(beat_cnt), 64'd1);
    chk("t1_byte", 64'(byte_cnt), 64'd4);
    idle(); tick();

    // 2: payload change while stalled
    do_reset();
    tvalid = 1; tdata = 32'h1; tick();
    tdata = 32'h2; tick();
    chk("t2_unstable", 64'(err_flags[1]), 64'd1);
    chk("t2_first", 64'(err_first), 64'd1);
    tready = 1; err_clear = 1; tick();
    chk("t2_clear", 64'(err_flags), 64'h0);
    idle(); tick();

    // 3: valid dropped, then strb outside keep
    do_reset();
    tvalid = 1; tick(); tick();
    tvalid = 0; tick();
    chk("t3_drop", 64'(err_flags[0]), 64'd1);
    tvalid = 1; tready = 1; tkeep = 4'b0011; tstrb = 4'b0100; tick();
    chk("t3_strb", 64'(err_flags[2]), 64'd1);
    chk("t3_drop_kept", 64'(err_flags[0]), 64'd1);
    chk("t3_first", 64'(err_first), 64'd0);
    idle(); tick();

    // 4: stall timeout exactly at the 4th stalled edge
    do_reset();
    tvalid = 1;
    repeat (3) tick();
    chk("t4_no_stall_yet", 64'(err_flags[4]), 64'd0);
    tick();
    chk("t4_stall", 64'(err_flags[4]), 64'd1);
    tready = 1; tick();
    idle(); tick();

    // 5: three-beat packet with a TID change on beat 2
    do_reset();
    tvalid = 1; tready = 1; tid = 0; tick();
    chk("t5_inpkt1", 64'(in_packet), 64'd1);
    tid = 1; tick();
    chk("t5_inpkt2", 64'(in_packet), 64'd1);
    chk("t5_route", 64'(err_flags[6]), 64'd1);
    tkeep = 4'h3; tstrb = 4'h3; tlast = 1; tick();
    chk("t5_inpkt3", 64'(in_packet), 64'd0);
    chk("t5_pkt", 64'(pkt_cnt), 64'd1);
    chk("t5_beat", 64'(beat_cnt), 64'd3);
    chk("t5_byte", 64'(byte_cnt), 64'd10);
    chk("t5_plen", 64'(pkt_beats), 64'd3);
    idle(); tick();
    chk("t5_plen_zero", 64'(pkt_beats), 64'd0);

    // packet longer than MAX_PKT_BEATS
    do_reset();
    tvalid = 1; tready = 1;
    repeat (MPB) tick();
    chk("pktlen_at_max", 64'(err_flags[5]), 64'd0);
    tick();
    chk("pktlen_over", 64'(err_flags[5]), 64'd1);

    // 6: reset mid-packet with tvalid high
    idle(); do_reset();
    tvalid = 1; tready = 1; tick();
    reset = 1; tick();
    reset = 0; tvalid = 0; tready = 0;
    chk("t6_flags", 64'(err_flags), 64'h08);
    chk("t6_first", 64'(err_first), 64'd3);
    chk("t6_beat", 64'(beat_cnt), 64'd0);
    chk("t6_inpkt", 64'(in_packet), 64'd0);
    chk("t6_plen", 64'(pkt_beats), 64'd0);
    tick();

    // counter saturation and stat_clear coinciding with a beat
    do_reset();
    tvalid = 1; tready = 1; tlast = 1;
    repeat (70) tick();
    chk("sat_byte", 64'(byte_cnt), 64'd255);
    chk("sat_beat", 64'(beat_cnt), 64'd70);
    stat_clear = 1; tick();
    chk("sclr_beat", 64'(beat_cnt), 64'd1);
    chk("sclr_byte", 64'(byte_cnt), 64'd4);
    idle(); tick();

    // randomized traffic with occasional violations
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (tvalid && !tready) begin
        if ($urandom_range(0, 99) < 3) tvalid = 0;
        else if ($urandom_range(0, 99) < 4) tdata = $urandom;
      end else begin
        tvalid = $urandom_range(0, 99) < 70;
        tdata = $urandom;
        tkeep = 4'($urandom_range(1, 15));
        tstrb = ($urandom_range(0, 99) < 5) ? 4'($urandom) : (tkeep & 4'($urandom));
        tlast = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 99) < 5) tid = 2'($urandom);
        if ($urandom_range(0, 99) < 3) tdest = 2'($urandom);
        tuser = 1'($urandom);
      end
      tready = $urandom_range(0, 99) < 60;
      err_clear = $urandom_range(0, 99) < 3;
      stat_clear = $urandom_range(0, 999) < 2;
      reset = $urandom_range(0, 999) < 3;
      tick();
    end
    reset = 0; idle(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
